tama_event_sched: RTL

Input-side controller for the pet datapath: conditions the six raw buttons, times 5 s long presses for reset and test mode, generates the one-second base tick and the per-stat decay events, and arbitrates all stat-update requests onto a single ready/valid update port driven into the stat-level datapath. It owns stat selection and test-mode state, so the datapath only executes INC/DEC/SET_MIN/SET_MAX commands.

---
 rtl/tama_event_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/tama_event_sched.sv
// tama_event_sched: button conditioning, long-press timers, decay events and update arbiter (debounce via TAMA_SCHED_DEBOUNCE_EN)
module tama_event_sched #(
  parameter int TICK_CYC      = 50_000_000,
  parameter int DEB_CYC       = 1_000_000,
  parameter int HOLD_S        = 5,
  parameter int PER_SALUD     = 120,
  parameter int PER_ENERGIA   = 100,
  parameter int PER_HAMBRE    = 70,
  parameter int PER_DIVERSION = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_salud,
  input  logic       btn_energia,
  input  logic       btn_hambre,
  input  logic       btn_diversion,
  input  logic       btn_reset,
  input  logic       btn_test,
  input  logic       upd_ready,
  output logic       upd_valid,
  output logic [1:0] upd_stat,
  output logic [1:0] upd_op,
  output logic       sys_reset,
  output logic       test_mode,
  output logic [1:0] sel_stat,
  output logic       sec_tick
);
  localparam int TW = $clog2(TICK_CYC + 1);
  localparam int HW = $clog2(HOLD_S + 1);
  localparam int PW = $clog2(PER_SALUD + PER_ENERGIA + PER_HAMBRE + PER_DIVERSION + 1);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state;
  logic [5:0] raw, s1, s2, deb;
  logic [3:0] deb_q, press, btn_pend, dec_pend, btn_set, dec_set, clr_b, clr_d, tm_hi;
  logic [TW-1:0] pcnt;
  logic [HW-1:0] hcnt [2];
  logic [PW-1:0] dcn [4];
  logic fire_r, fire_t, enter, acc, cls;
  logic [1:0] bsel, dsel;

  function automatic logic [PW-1:0] per_m1(input int i);
    return PW'(i == 0 ? PER_SALUD - 1 : i == 1 ? PER_ENERGIA - 1 : i == 2 ? PER_HAMBRE - 1 : PER_DIVERSION - 1);
  endfunction

  function automatic logic [1:0] lowest(input logic [3:0] v);
    return v[0] ? 2'd0 : v[1] ? 2'd1 : v[2] ? 2'd2 : 2'd3;
  endfunction

  assign raw = {btn_test, btn_reset, btn_diversion, btn_hambre, btn_energia, btn_salud};

`ifdef TAMA_SCHED_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYC + 1);
  logic [DW-1:0] dbc [6];
  always_ff @(posedge clk) begin
    if (rst) begin
      deb <= '0;
      dbc <= '{default: '0};
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (s2[i] == deb[i]) dbc[i] <= '0;
        else if (dbc[i] == DW'(DEB_CYC - 1)) begin
          deb[i] <= s2[i];
          dbc[i] <= '0;
        end else dbc[i] <= dbc[i] + 1'b1;
      end
    end
  end
`else
  logic unused_deb;
  assign unused_deb = DEB_CYC > 0;
  assign deb = s2;
`endif

  always_comb begin
    press = deb[3:0] & ~deb_q;
    fire_r = sec_tick && deb[4] && hcnt[0] == HW'(HOLD_S - 1);
    fire_t = sec_tick && deb[5] && hcnt[1] == HW'(HOLD_S - 1);
    enter = fire_t && !test_mode;
    acc = state == OFFER && upd_ready;
    clr_b = (acc && !cls) ? 4'b1 << upd_stat : 4'b0;
    clr_d = (acc && cls) ? 4'b1 << upd_stat : 4'b0;
    bsel = lowest(btn_pend);
    dsel = lowest(dec_pend);
    dec_set = '0;
    btn_set = '0;
    for (int i = 0; i < 4; i++) begin
      dec_set[i] = sec_tick && !test_mode && dcn[i] == per_m1(i);
      btn_set[i] = press[i] && !deb[4] && sel_stat == 2'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      deb_q <= '0;
      pcnt <= '0;
      sec_tick <= 1'b0;
      hcnt <= '{default: '0};
      sys_reset <= 1'b0;
      test_mode <= 1'b0;
      sel_stat <= 2'd0;
      btn_pend <= '0;
      dec_pend <= '0;
      tm_hi <= '0;
      dcn <= '{default: '0};
      state <= IDLE;
      upd_valid <= 1'b0;
      upd_stat <= 2'd0;
      upd_op <= 2'd0;
      cls <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      deb_q <= deb[3:0];
      pcnt <= (pcnt == TW'(TICK_CYC - 1)) ? '0 : pcnt + 1'b1;
      sec_tick <= pcnt == TW'(TICK_CYC - 1);
      // hold counters saturate at HOLD_S so a long press fires once until release
      for (int j = 0; j < 2; j++)
        hcnt[j] <= !deb[4 + j] ? '0 : (sec_tick && hcnt[j] != HW'(HOLD_S)) ? hcnt[j] + 1'b1 : hcnt[j];
      sys_reset <= fire_r;
      if (sys_reset) begin
        test_mode <= 1'b0;
        sel_stat <= 2'd0;
        btn_pend <= '0;
        dec_pend <= '0;
        tm_hi <= '0;
        dcn <= '{default: '0};
        state <= IDLE;
        upd_valid <= 1'b0;
        upd_stat <= 2'd0;
        upd_op <= 2'd0;
        cls <= 1'b0;
      end else begin
        test_mode <= test_mode ^ fire_t;
        for (int i = 0; i < 4; i++) begin
          if (press[i] && !deb[4] && sel_stat != 2'(i)) sel_stat <= 2'(i);
          if (enter) dcn[i] <= '0;
          else if (sec_tick && !test_mode) dcn[i] <= dec_set[i] ? '0 : dcn[i] + 1'b1;
        end
        btn_pend <= (btn_pend & ~clr_b) | btn_set;
        dec_pend <= enter ? '0 : (dec_pend & ~clr_d) | dec_set;
        if (acc && !cls && upd_op[1]) tm_hi[upd_stat] <= ~tm_hi[upd_stat];
        // button requests outrank decay; lowest stat index wins inside a class
        if (state == IDLE && (|btn_pend || |dec_pend)) begin
          state <= OFFER;
          upd_valid <= 1'b1;
          cls <= ~|btn_pend;
          upd_stat <= |btn_pend ? bsel : dsel;
          upd_op <= !(|btn_pend) ? 2'b01 : test_mode ? {1'b1, tm_hi[bsel]} : 2'b00;
        end else if (acc) begin
          state <= IDLE;
          upd_valid <= 1'b0;
        end
      end
    end
  end
endmodule
